// File: rtl/ncl_counter_sequencer.sv
// ncl_counter_sequencer
//   Clocked front end for the dual-rail NCL counter ring. It arbitrates two
//   synchronous increment clients, issues one DATA/NULL wavefront on the
//   ring's carry-in for each grant, consumes the sum and carry-out digits, and
//   mirrors them into a binary count with a sticky overflow flag.
//
// Ports
//   clk        rising-edge clock
//   init       asynchronous active-high reset (shared with the ring)
//   req[1:0]   per-client increment request (level, held until ack)
//   ack[1:0]   one-cycle completion pulse for the granted client
//   cin_t/f    dual-rail carry-in to digit 0 (registered)
//   cin_comp   digit-0 completion (async): 1 = DATA taken, 0 = NULL taken
//   sum_t/f    dual-rail sum digits (async)
//   sum_comp   per-digit consume acknowledge
//   cout_t/f   dual-rail carry-out of the top digit (async)
//   cout_comp  carry-out consume acknowledge
//   count      binary mirror of the captured sum digits
//   ovf        sticky carry-out DATA-1
//   busy       FSM not in IDLE
//   err        sticky handshake timeout or illegal (1,1) rail code

// Per-digit consumer: synchronizes one dual-rail pair and keeps the captured
// value plus the completion it returns to the ring.
module ncl_digit_consume #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic init,
  input  logic i_t,
  input  logic i_f,
  output logic o_val,
  output logic o_comp,
  output logic o_illegal
);
  logic [SYNC_STAGES-1:0] r_t_sync, r_f_sync;
  logic                   r_val, r_comp;
  logic                   w_t, w_f;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_t_sync <= '0;
      r_f_sync <= '0;
    end else begin
      r_t_sync <= {r_t_sync[SYNC_STAGES-2:0], i_t};
      r_f_sync <= {r_f_sync[SYNC_STAGES-2:0], i_f};
    end
  end

  assign w_t = r_t_sync[SYNC_STAGES-1];
  assign w_f = r_f_sync[SYNC_STAGES-1];

  // DATA captures and acknowledges; NULL releases the acknowledge but keeps
  // the value; (1,1) is illegal and leaves everything as it was.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_val  <= 1'b0;
      r_comp <= 1'b0;
    end else begin
      case ({w_t, w_f})
        2'b10:   begin r_val <= 1'b1; r_comp <= 1'b1; end
        2'b01:   begin r_val <= 1'b0; r_comp <= 1'b1; end
        2'b00:   r_comp <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_val     = r_val;
  assign o_comp    = r_comp;
  assign o_illegal = w_t & w_f;
endmodule

module ncl_counter_sequencer #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             init,
  input  logic [1:0]       req,
  output logic [1:0]       ack,
  output logic             cin_t,
  output logic             cin_f,
  input  logic             cin_comp,
  input  logic [WIDTH-1:0] sum_t,
  input  logic [WIDTH-1:0] sum_f,
  output logic [WIDTH-1:0] sum_comp,
  input  logic             cout_t,
  input  logic             cout_f,
  output logic             cout_comp,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             busy,
  output logic             err
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_NULL, S_DONE, S_ERR} state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_cc_sync;
  logic                   w_cc;
  logic [TW-1:0]          r_tmo;
  logic                   r_grant, r_prio, w_grant_new;
  logic [1:0]             r_ack;
  logic                   r_cin_t, r_err, r_ovf;
  logic [WIDTH-1:0]       w_sum_illegal;
  logic                   w_cout_val, w_cout_illegal;

  // Digit consumers, one per sum digit plus one for the carry-out.
  for (genvar g = 0; g < WIDTH; g++) begin : g_digit
    ncl_digit_consume #(.SYNC_STAGES(SYNC_STAGES)) u_digit (
      .clk       (clk),
      .init      (init),
      .i_t       (sum_t[g]),
      .i_f       (sum_f[g]),
      .o_val     (count[g]),
      .o_comp    (sum_comp[g]),
      .o_illegal (w_sum_illegal[g])
    );
  end

  ncl_digit_consume #(.SYNC_STAGES(SYNC_STAGES)) u_cout (
    .clk       (clk),
    .init      (init),
    .i_t       (cout_t),
    .i_f       (cout_f),
    .o_val     (w_cout_val),
    .o_comp    (cout_comp),
    .o_illegal (w_cout_illegal)
  );

  always_ff @(posedge clk or posedge init) begin
    if (init) r_cc_sync <= '0;
    else      r_cc_sync <= {r_cc_sync[SYNC_STAGES-2:0], cin_comp};
  end
  assign w_cc = r_cc_sync[SYNC_STAGES-1];

  // With both clients asking, the priority holder wins; otherwise whoever asks.
  assign w_grant_new = (req == 2'b11) ? r_prio : req[1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|req) w_next = S_DATA;
      S_DATA: begin
        if (w_cc)                   w_next = S_NULL;
        else if (r_tmo == TMO_LAST) w_next = S_ERR;
      end
      S_NULL: begin
        if (!w_cc)                  w_next = S_DONE;
        else if (r_tmo == TMO_LAST) w_next = S_ERR;
      end
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
      r_ack   <= 2'b00;
      r_cin_t <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      // cin is driven from the next state so it changes on the same edge as
      // the FSM and is glitch-free toward the ring.
      r_cin_t <= (w_next == S_DATA);
      r_ack   <= (w_next == S_DONE) ? 2'(2'b01 << r_grant) : 2'b00;
      if (r_state == S_IDLE && w_next == S_DATA) r_grant <= w_grant_new;
      if (r_state == S_DONE)                     r_prio  <= ~r_grant;
      // Timeout restarts on every state change, so each handshake phase gets
      // its own budget.
      if (w_next != r_state)                            r_tmo <= '0;
      else if (r_state == S_DATA || r_state == S_NULL)  r_tmo <= r_tmo + 1'b1;
      r_err <= r_err | (|w_sum_illegal) | w_cout_illegal | (w_next == S_ERR);
      r_ovf <= r_ovf | w_cout_val;
    end
  end

  assign ack   = r_ack;
  assign cin_t = r_cin_t;
  // Only increments are ever issued, so the false rail never carries DATA.
  assign cin_f = 1'b0;
  assign ovf   = r_ovf;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_ncl_counter_sequencer.sv
`timescale 1ns/1ps
module tb_ncl_counter_sequencer;
  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TMO   = 60;
  localparam int LAT   = 2 * (SYNC + 1);
  localparam logic [WIDTH-1:0] BIT5 = WIDTH'(1) << 5;

  logic             clk = 1'b0;
  logic             init = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       ack;
  logic             cin_t, cin_f;
  logic             cin_comp = 1'b0;
  logic [WIDTH-1:0] sum_t, sum_f, sum_comp, count;
  logic             cout_t, cout_f, cout_comp, ovf, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural ring: the whole counter is one integer that advances by one
  // on each carry-in DATA and shows its digits on the sum rails until NULL.
  logic [WIDTH-1:0] ring_val = '0, ring_st = '0, ring_sf = '0, preload_val = '0;
  logic             ring_ct = 1'b0, ring_cf = 1'b0, ring_data = 1'b0;
  logic             load_tog = 1'b0, seen_tog = 1'b0;
  logic             stall = 1'b0, force5 = 1'b0;

  assign sum_t  = ring_st | (force5 ? BIT5 : '0);
  assign sum_f  = ring_sf | (force5 ? BIT5 : '0);
  assign cout_t = ring_ct;
  assign cout_f = ring_cf;

  always @(posedge cin_t or negedge cin_t or posedge init or load_tog) begin
    logic [WIDTH:0] nxt;
    if (init) begin
      ring_val = '0; ring_st = '0; ring_sf = '0; ring_ct = 0; ring_cf = 0;
      cin_comp = 0; ring_data = 0; seen_tog = load_tog;
    end else begin
      if (load_tog != seen_tog) begin
        seen_tog = load_tog;
        ring_val = preload_val;
      end
      if (cin_t && !ring_data) begin
        nxt = {1'b0, ring_val} + 1;
        ring_val = nxt[WIDTH-1:0];
        ring_st = nxt[WIDTH-1:0]; ring_sf = ~nxt[WIDTH-1:0];
        ring_ct = nxt[WIDTH];     ring_cf = ~nxt[WIDTH];
        ring_data = 1;
        if (!stall) cin_comp = 1;
      end else if (!cin_t && ring_data) begin
        ring_st = '0; ring_sf = '0; ring_ct = 0; ring_cf = 0;
        ring_data = 0;
        cin_comp = 0;
      end
    end
  end

  ncl_counter_sequencer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .init(init), .req(req), .ack(ack), .cin_t(cin_t), .cin_f(cin_f),
    .cin_comp(cin_comp), .sum_t(sum_t), .sum_f(sum_f), .sum_comp(sum_comp),
    .cout_t(cout_t), .cout_f(cout_f), .cout_comp(cout_comp), .count(count),
    .ovf(ovf), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic do_reset;
    req = 2'b00; stall = 0; force5 = 0; init = 1;
    repeat (2) @(negedge clk);
    init = 0;
    @(negedge clk);
  endtask

  task automatic preload(input logic [WIDTH-1:0] v);
    preload_val = v;
    load_tog = ~load_tog;
    #1;
  endtask

  // Waits (bounded) for an ack; lat counts negedges after the first one.
  task automatic wait_ack(output logic [1:0] got, output int lat);
    lat = 0;
    @(negedge clk);
    while (ack == 2'b00 && lat < 400) begin @(negedge clk); lat++; end
    got = ack;
  endtask

  task automatic test_reset;
    init = 1; req = 2'b11;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_checks++; if (cin_t !== 1'b0 || cin_f !== 1'b0) begin n_fail++; $display("FAIL reset_cin: got %b%b want 00", cin_t, cin_f); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got err=%b ovf=%b want 0 0", err, ovf); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %h want 0", count); end
    n_checks++; if (sum_comp !== '0 || cout_comp !== 1'b0) begin n_fail++; $display("FAIL reset_comp: got %h %b want 0 0", sum_comp, cout_comp); end
    req = 2'b00; init = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat;
    logic [1:0] seen;
    do_reset;
    req = 2'b01;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || cin_t !== 1'b1) begin n_fail++; $display("FAIL single_launch: got busy=%b cin_t=%b want 1 1", busy, cin_t); end
    lat = 0;
    while (ack == 2'b00 && lat < 400) begin @(negedge clk); lat++; end
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", ack); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    req = 2'b00;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 00", ack); end
    seen = 2'b00;
    repeat (10) begin @(negedge clk); seen |= ack; end
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL single_extra_ack: got %b want 00", seen); end
    n_checks++; if (count !== WIDTH'(1)) begin n_fail++; $display("FAIL single_count: got %h want 1", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
    n_checks++; if (sum_comp !== '0 || cout_comp !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL single_comp: got %h %b ovf=%b want 0 0 0", sum_comp, cout_comp, ovf); end
  endtask

  task automatic test_simultaneous;
    logic [1:0] got;
    int lat;
    logic prio;
    req = 2'b11; init = 1; stall = 0; force5 = 0;
    repeat (2) @(negedge clk);
    init = 0;
    prio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(got, lat);
      n_checks++; if (got !== (2'b01 << prio)) begin n_fail++; $display("FAIL simul_grant%0d: got %b want %b", i, got, 2'b01 << prio); end
      prio = ~prio;
    end
    req = 2'b00;
    repeat (10) @(negedge clk);
    n_checks++; if (count !== WIDTH'(4)) begin n_fail++; $display("FAIL simul_count: got %h want 4", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrap;
    logic [1:0] got;
    int lat;
    do_reset;
    preload('1);
    req = 2'b01; wait_ack(got, lat); req = 2'b00;
    repeat (4) @(negedge clk);
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL wrap_count: got %h want 0", count); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", ovf); end
    for (int i = 0; i < 3; i++) begin
      req = 2'b10; wait_ack(got, lat); req = 2'b00;
      n_checks++; if (got !== 2'b10) begin n_fail++; $display("FAIL wrap_ack%0d: got %b want 10", i, got); end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (ovf !== 1'b1 || count !== WIDTH'(3)) begin n_fail++; $display("FAIL wrap_sticky: got ovf=%b count=%h want 1 3", ovf, count); end
    do_reset;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_timeout;
    logic [1:0] seen;
    do_reset;
    stall = 1;
    req = 2'b01;
    @(negedge clk);
    seen = ack;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      seen |= ack;
      if (k == TMO - 1) begin
        n_checks++; if (err !== 1'b0 || cin_t !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got err=%b cin_t=%b want 0 1", err, cin_t); end
      end
    end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
    n_checks++; if (cin_t !== 1'b0 || cin_f !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_state: got cin=%b%b busy=%b want 00 1", cin_t, cin_f, busy); end
    req = 2'b00;
    repeat (20) begin @(negedge clk); seen |= ack; end
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL tmo_no_ack: got %b want 00", seen); end
    n_checks++; if (err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_stuck: got err=%b busy=%b want 1 1", err, busy); end
    do_reset;
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got err=%b busy=%b want 0 0", err, busy); end
  endtask

  task automatic test_illegal;
    logic [WIDTH-1:0] v, exp;
    logic [1:0] got, m;
    int lat;
    do_reset;
    v = WIDTH'($urandom_range(0, 32'h7fff_0000));
    preload(v);
    req = 2'b01; wait_ack(got, lat); req = 2'b00;
    exp = v + 1;
    force5 = 1;
    repeat (5) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
    for (int i = 0; i < 3; i++) begin
      m = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      req = m; wait_ack(got, lat); req = 2'b00;
      n_checks++; if (got !== m) begin n_fail++; $display("FAIL illegal_seq%0d: got %b want %b", i, got, m); end
      exp = ((v + WIDTH'(i + 2)) & ~BIT5) | (exp & BIT5);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (count !== exp) begin n_fail++; $display("FAIL illegal_count: got %h want %h", count, exp); end
    n_checks++; if (sum_comp[5] !== 1'b0) begin n_fail++; $display("FAIL illegal_comp5: got %b want 0", sum_comp[5]); end
    force5 = 0;
  endtask

  task automatic test_reset_mid;
    logic [1:0] got, seen;
    int lat;
    do_reset;
    req = 2'b01;
    @(negedge clk);
    #2 init = 1;
    #1;
    n_checks++; if (cin_t !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin n_fail++; $display("FAIL mid_abort: got cin_t=%b busy=%b ack=%b want 0 0 00", cin_t, busy, ack); end
    n_checks++; if (count !== '0 || err !== 1'b0 || sum_comp !== '0) begin n_fail++; $display("FAIL mid_regs: got count=%h err=%b comp=%h want 0 0 0", count, err, sum_comp); end
    req = 2'b00;
    @(negedge clk);
    init = 0;
    seen = 2'b00;
    repeat (10) begin @(negedge clk); seen |= ack; end
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL mid_no_ack: got %b want 00", seen); end
    req = 2'b01; wait_ack(got, lat); req = 2'b00;
    repeat (4) @(negedge clk);
    n_checks++; if (got !== 2'b01 || count !== WIDTH'(1)) begin n_fail++; $display("FAIL mid_recover: got ack=%b count=%h want 01 1", got, count); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] v;
    logic [1:0] got, m;
    logic prio, g;
    int lat;
    do_reset;
    v = WIDTH'($urandom_range(0, 32'h7fff_0000));
    preload(v);
    prio = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom_range(1, 3));
      g = (m == 2'b11) ? prio : m[1];
      req = m;
      wait_ack(got, lat);
      req = 2'b00;
      n_checks++; if (got !== (2'b01 << g) || lat != ((i == 0) ? LAT : LAT + 1)) begin n_fail++; $display("FAIL rand_txn%0d: got ack=%b lat=%0d want %b %0d", i, got, lat, 2'b01 << g, (i == 0) ? LAT : LAT + 1); end
      prio = ~g;
      v = v + 1;
    end
    repeat (6) @(negedge clk);
    n_checks++; if (count !== v || ovf !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rand_final: got count=%h ovf=%b err=%b want %h 0 0", count, ovf, err, v); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_wrap;
    test_timeout;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
